// File: rtl/npu_pkg.sv
// Shared definitions for the NPU host load sequencer: state encoding,
// command bit positions and load sizes.
package npu_pkg;

   localparam int IMG_WORDS = 224;    // image words per load (4 pixels/word)
   localparam int W_BYTES   = 37630;  // weight + bias bytes per load
   localparam int IMG_AW    = 8;
   localparam int W_AW      = 16;

   // Bit positions inside control_reg
   localparam int CMD_LOAD  = 0;
   localparam int CMD_RUN   = 1;
   localparam int CMD_ABORT = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_IMG = 3'd1,
      ST_LOAD_W   = 3'd2,
      ST_LOADED   = 3'd3,
      ST_RUN      = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

endpackage

// File: rtl/npu_load_seq_ctrl_if.sv
// Host/RAM/engine signal bundle for the load sequencer.
//
// Handshake: there is no ready. A host beat is writedata qualified by
// wr_valid for one cycle; it is accepted only in LOAD_IMG/LOAD_W and shows up
// as a one-cycle RAM write strobe (img_we or w_we) exactly one cycle later.
// Beats presented in any other state are dropped and flagged in status[7].
interface npu_load_seq_ctrl_if;
   import npu_pkg::*;

   logic [31:0]       control_reg;
   logic [31:0]       writedata;
   logic              wr_valid;
   logic              img_we;
   logic [IMG_AW-1:0] img_addr;
   logic [31:0]       img_wdata;
   logic              w_we;
   logic [W_AW-1:0]   w_addr;
   logic [7:0]        w_wdata;
   logic              npu_start;
   logic              npu_abort;
   logic              npu_done;
   logic              busy;
   logic              done;
   logic [7:0]        status;

   // Host / environment side
   modport master (
      output control_reg, writedata, wr_valid, npu_done,
      input  img_we, img_addr, img_wdata, w_we, w_addr, w_wdata,
             npu_start, npu_abort, busy, done, status
   );

   // Sequencer side
   modport slave (
      input  control_reg, writedata, wr_valid, npu_done,
      output img_we, img_addr, img_wdata, w_we, w_addr, w_wdata,
             npu_start, npu_abort, busy, done, status
   );

endinterface

// File: rtl/npu_cmd_edge.sv
// Rising-edge detector for the three command bits of control_reg.
// Reset loads the current command value so a bit already high at reset
// release does not look like a new command.
module npu_cmd_edge (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] cmd_in,
   output logic [2:0] rise
);

   logic [2:0] prev;

   // Track previous command bits; reset and run both load the live value
   always_ff @(posedge clk) begin
      if (reset) prev <= cmd_in;
      else       prev <= cmd_in;
   end

   // Edge is only meaningful once out of reset
   always_comb begin
      rise = reset ? 3'b000 : (cmd_in & ~prev);
   end

endmodule

// File: rtl/npu_load_seq_ctrl.sv
// Host-side sequencer: decodes command edges, streams counted image and
// weight beats into their RAMs with one cycle of latency, then starts the
// compute engine and tracks completion. status = {err_ovr, err_seq, 0, state}.
module npu_load_seq_ctrl
   import npu_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   npu_load_seq_ctrl_if.slave  bus
);

   localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_WORDS - 1);
   localparam logic [W_AW-1:0]   W_LAST   = W_AW'(W_BYTES - 1);

   state_t            state, state_n;
   logic [IMG_AW-1:0] img_cnt, img_cnt_n;
   logic [W_AW-1:0]   w_cnt, w_cnt_n;
   logic              err_ovr, err_ovr_n;
   logic              err_seq, err_seq_n;

   logic              img_we_q, img_we_n;
   logic [IMG_AW-1:0] img_addr_q, img_addr_n;
   logic [31:0]       img_wdata_q, img_wdata_n;
   logic              w_we_q, w_we_n;
   logic [W_AW-1:0]   w_addr_q, w_addr_n;
   logic [7:0]        w_wdata_q, w_wdata_n;
   logic              start_q, start_n;
   logic              abort_q, abort_n;

   logic [2:0]        rise;
   logic              cmd_load, cmd_run, cmd_abort;
   logic              take_img, take_w, drop;
   logic              unused_ctrl;

   assign unused_ctrl = ^bus.control_reg[31:3];

   npu_cmd_edge u_cmd_edge (
      .clk    (clk),
      .reset  (reset),
      .cmd_in (bus.control_reg[2:0]),
      .rise   (rise)
   );

   assign cmd_load  = rise[CMD_LOAD];
   assign cmd_run   = rise[CMD_RUN];
   assign cmd_abort = rise[CMD_ABORT];

   // Next state, counters, error flags and registered RAM/engine strobes
   always_comb begin
      state_n     = state;
      img_cnt_n   = img_cnt;
      w_cnt_n     = w_cnt;
      err_ovr_n   = err_ovr;
      err_seq_n   = err_seq;
      img_we_n    = 1'b0;
      img_addr_n  = img_addr_q;
      img_wdata_n = img_wdata_q;
      w_we_n      = 1'b0;
      w_addr_n    = w_addr_q;
      w_wdata_n   = w_wdata_q;
      start_n     = 1'b0;
      abort_n     = 1'b0;

      take_img = bus.wr_valid && (state == ST_LOAD_IMG);
      take_w   = bus.wr_valid && (state == ST_LOAD_W);
      drop     = bus.wr_valid && !take_img && !take_w;

      // Beats accepted this cycle are written even if an abort arrives too
      if (take_img) begin
         img_we_n    = 1'b1;
         img_addr_n  = img_cnt;
         img_wdata_n = bus.writedata;
         img_cnt_n   = img_cnt + 1'b1;
         if (img_cnt == IMG_LAST) state_n = ST_LOAD_W;
      end
      if (take_w) begin
         w_we_n    = 1'b1;
         w_addr_n  = w_cnt;
         w_wdata_n = bus.writedata[7:0];
         w_cnt_n   = w_cnt + 1'b1;
         if (w_cnt == W_LAST) state_n = ST_LOADED;
      end

      // Only the highest-priority command edge is acted on
      if (cmd_abort) begin
         state_n = ST_IDLE;
         abort_n = (state == ST_RUN);
      end else begin
         if (cmd_load) begin
            if (state == ST_IDLE || state == ST_LOADED || state == ST_DONE) begin
               state_n   = ST_LOAD_IMG;
               img_cnt_n = '0;
               w_cnt_n   = '0;
               err_ovr_n = 1'b0;
               err_seq_n = 1'b0;
            end else begin
               err_seq_n = 1'b1;
            end
         end else if (cmd_run) begin
            if (state == ST_LOADED || state == ST_DONE) begin
               state_n = ST_RUN;
               start_n = 1'b1;
            end else begin
               err_seq_n = 1'b1;
            end
         end
         if (state == ST_RUN && bus.npu_done) state_n = ST_DONE;
      end

      // A dropped beat in the same cycle as an accepted LOAD still flags
      if (drop) err_ovr_n = 1'b1;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         img_cnt     <= '0;
         w_cnt       <= '0;
         err_ovr     <= 1'b0;
         err_seq     <= 1'b0;
         img_we_q    <= 1'b0;
         img_addr_q  <= '0;
         img_wdata_q <= '0;
         w_we_q      <= 1'b0;
         w_addr_q    <= '0;
         w_wdata_q   <= '0;
         start_q     <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state       <= state_n;
         img_cnt     <= img_cnt_n;
         w_cnt       <= w_cnt_n;
         err_ovr     <= err_ovr_n;
         err_seq     <= err_seq_n;
         img_we_q    <= img_we_n;
         img_addr_q  <= img_addr_n;
         img_wdata_q <= img_wdata_n;
         w_we_q      <= w_we_n;
         w_addr_q    <= w_addr_n;
         w_wdata_q   <= w_wdata_n;
         start_q     <= start_n;
         abort_q     <= abort_n;
      end
   end

   assign bus.img_we    = img_we_q;
   assign bus.img_addr  = img_addr_q;
   assign bus.img_wdata = img_wdata_q;
   assign bus.w_we      = w_we_q;
   assign bus.w_addr    = w_addr_q;
   assign bus.w_wdata   = w_wdata_q;
   assign bus.npu_start = start_q;
   assign bus.npu_abort = abort_q;
   assign bus.busy      = (state == ST_LOAD_IMG) || (state == ST_LOAD_W) || (state == ST_RUN);
   assign bus.done      = (state == ST_DONE);
   assign bus.status    = {err_ovr, err_seq, 3'b000, state};

endmodule

// File: tb/tb_npu_load_seq_ctrl.sv
// Bench for npu_load_seq_ctrl: directed command/beat sequences, a cycle
// model of the sequencer rules checked on every falling edge, and literal
// checks at the key points of each scenario.
module tb_npu_load_seq_ctrl;

   localparam int N_IMG = 224;
   localparam int N_W   = 37630;

   logic clk;
   logic reset;

   npu_load_seq_ctrl_if bus ();

   npu_load_seq_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- counters / scoreboard state ----------------
   int vectors = 0;
   int miscompares = 0;

   int img_we_cnt = 0;
   int w_we_cnt = 0;
   int start_cnt = 0;
   int abort_cnt = 0;
   int last_img_addr = -1;
   int last_w_addr = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d);
      bus.wr_valid  = 1'b1;
      bus.writedata = d;
      tick();
      bus.wr_valid  = 1'b0;
   endtask

   task automatic clear_counts();
      img_we_cnt    = 0;
      w_we_cnt      = 0;
      start_cnt     = 0;
      abort_cnt     = 0;
      last_img_addr = -1;
      last_w_addr   = -1;
   endtask

   function automatic logic [31:0] img_word(input int i);
      return (i * 32'h0101_0101) ^ 32'hC0DE_0000;
   endfunction

   // ---------------- model + compare ----------------
   // Model: m_st holds the spec state number; e_* are the outputs the
   // sequencer must present after the next rising edge.
   int          m_st = 0;
   int          m_icnt = 0;
   int          m_wcnt = 0;
   bit          m_ovr = 0;
   bit          m_seq = 0;
   bit [2:0]    m_prev = 0;
   bit          m_valid = 0;
   bit          e_img_we = 0, e_w_we = 0, e_start = 0, e_abort = 0;
   logic [31:0] e_img_addr = 0, e_img_wdata = 0, e_w_addr = 0, e_w_wdata = 0;

   initial begin
      bit [2:0] rise;
      int       nst;
      bit       drop;
      logic [7:0] e_status;
      forever begin
         @(negedge clk);
         // monitor
         if (bus.img_we === 1'b1) begin img_we_cnt++; last_img_addr = int'(bus.img_addr); end
         if (bus.w_we === 1'b1)   begin w_we_cnt++;   last_w_addr   = int'(bus.w_addr);   end
         if (bus.npu_start === 1'b1) start_cnt++;
         if (bus.npu_abort === 1'b1) abort_cnt++;

         // compare outputs produced by the last rising edge
         if (m_valid) begin
            e_status = {m_ovr, m_seq, 3'b000, m_st[2:0]};
            chk("img_we", 32'(bus.img_we), 32'(e_img_we));
            if (e_img_we) begin
               chk("img_addr", 32'(bus.img_addr), e_img_addr);
               chk("img_wdata", bus.img_wdata, e_img_wdata);
            end
            chk("w_we", 32'(bus.w_we), 32'(e_w_we));
            if (e_w_we) begin
               chk("w_addr", 32'(bus.w_addr), e_w_addr);
               chk("w_wdata", 32'(bus.w_wdata), e_w_wdata);
            end
            chk("npu_start", 32'(bus.npu_start), 32'(e_start));
            chk("npu_abort", 32'(bus.npu_abort), 32'(e_abort));
            chk("busy", 32'(bus.busy), 32'(m_st == 1 || m_st == 2 || m_st == 4));
            chk("done", 32'(bus.done), 32'(m_st == 5));
            chk("status", 32'(bus.status), 32'(e_status));
         end

         // step the model with the inputs the next rising edge will sample
         if (reset) begin
            m_st = 0; m_icnt = 0; m_wcnt = 0; m_ovr = 0; m_seq = 0;
            m_prev = bus.control_reg[2:0];
            e_img_we = 0; e_w_we = 0; e_start = 0; e_abort = 0;
            e_img_addr = 0; e_img_wdata = 0; e_w_addr = 0; e_w_wdata = 0;
         end else begin
            rise   = bus.control_reg[2:0] & ~m_prev;
            m_prev = bus.control_reg[2:0];
            nst = m_st; drop = 0;
            e_img_we = 0; e_w_we = 0; e_start = 0; e_abort = 0;
            if (bus.wr_valid) begin
               if (m_st == 1) begin
                  e_img_we = 1; e_img_addr = m_icnt; e_img_wdata = bus.writedata;
                  m_icnt++;
                  if (m_icnt == N_IMG) nst = 2;
               end else if (m_st == 2) begin
                  e_w_we = 1; e_w_addr = m_wcnt; e_w_wdata = bus.writedata & 32'hFF;
                  m_wcnt++;
                  if (m_wcnt == N_W) nst = 3;
               end else begin
                  drop = 1;
               end
            end
            if (rise[2]) begin
               nst = 0;
               e_abort = (m_st == 4);
            end else begin
               if (rise[0]) begin
                  if (m_st == 0 || m_st == 3 || m_st == 5) begin
                     nst = 1; m_icnt = 0; m_wcnt = 0; m_ovr = 0; m_seq = 0;
                  end else m_seq = 1;
               end else if (rise[1]) begin
                  if (m_st == 3 || m_st == 5) begin nst = 4; e_start = 1; end
                  else m_seq = 1;
               end
               if (m_st == 4 && bus.npu_done) nst = 5;
            end
            if (drop) m_ovr = 1;
            m_st = nst;
         end
         m_valid = 1;
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      reset           = 1'b1;
      bus.control_reg = 32'h7;
      bus.writedata   = 32'h0;
      bus.wr_valid    = 1'b0;
      bus.npu_done    = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      // reset state, bits already high at release give no command
      chk("rst_status", 32'(bus.status), 32'h00);
      chk("rst_busy", 32'(bus.busy), 32'h0);

      // 6a: all three commands at once in IDLE -> abort wins
      bus.control_reg = 32'h0; tick();
      bus.control_reg = 32'h7; tick();
      tick();
      chk("t6_all_cmds_status", 32'(bus.status), 32'h00);

      // 1: full load; 5: RUN during LOAD_W and beats in LOADED
      bus.control_reg = 32'h0; tick();
      clear_counts();
      bus.control_reg = 32'h1; tick();
      chk("t1_load_status", 32'(bus.status), 32'h01);
      for (int i = 0; i < N_IMG; i++) begin
         beat(img_word(i));
         if (i % 37 == 5) tick();
      end
      for (int j = 0; j < N_W; j++) begin
         if (j == 500) bus.control_reg = 32'h3;
         beat({16'hBEEF, 16'(j)});
      end
      chk("t1_loaded_state", 32'(bus.status[2:0]), 32'd3);
      chk("t1_busy_fall", 32'(bus.busy), 32'h0);
      chk("t1_last_w_we", 32'(bus.w_we), 32'h1);
      tick();
      chk("t1_img_we_count", 32'(img_we_cnt), 32'd224);
      chk("t1_last_img_addr", 32'(last_img_addr), 32'd223);
      chk("t1_last_w_addr", 32'(last_w_addr), 32'd37629);
      chk("t1_w_we_count", 32'(w_we_cnt), 32'd37630);
      chk("t5_no_start", 32'(start_cnt), 32'd0);
      chk("t5_err_seq", 32'(bus.status[6]), 32'h1);
      for (int k = 0; k < 10; k++) beat(32'h5555_0000 + 32'(k));
      tick();
      chk("t5_no_strobes", 32'(img_we_cnt + w_we_cnt), 32'd37854);
      chk("t5_err_ovr_status", 32'(bus.status), 32'hC3);

      // 2: RUN from LOADED, engine finishes after 50 cycles
      bus.control_reg = 32'h0; tick();
      start_cnt = 0;
      bus.control_reg = 32'h2; tick();
      chk("t2_start", 32'(bus.npu_start), 32'h1);
      chk("t2_run_state", 32'(bus.status[2:0]), 32'd4);
      repeat (49) tick();
      chk("t2_start_once", 32'(start_cnt), 32'd1);
      bus.npu_done = 1'b1; tick();
      bus.npu_done = 1'b0;
      chk("t2_done", 32'(bus.done), 32'h1);
      chk("t2_done_status", 32'(bus.status), 32'hC5);

      // 4: RUN again from DONE, then ABORT during RUN
      bus.control_reg = 32'h0; tick();
      bus.control_reg = 32'h2; tick();
      chk("t4_run_state", 32'(bus.status[2:0]), 32'd4);
      abort_cnt = 0;
      bus.control_reg = 32'h6; tick();
      chk("t4_abort_pulse", 32'(bus.npu_abort), 32'h1);
      chk("t4_idle", 32'(bus.status[2:0]), 32'd0);
      tick();
      bus.npu_done = 1'b1; tick();
      bus.npu_done = 1'b0; tick();
      chk("t4_done_low", 32'(bus.done), 32'h0);
      chk("t4_abort_once", 32'(abort_cnt), 32'd1);

      // 3: ABORT at image beat 100, then a fresh LOAD restarts at 0
      bus.control_reg = 32'h0; tick();
      bus.control_reg = 32'h1; tick();
      chk("t3_errs_cleared", 32'(bus.status), 32'h01);
      clear_counts();
      for (int i = 0; i < 100; i++) beat(img_word(i));
      bus.control_reg = 32'h4;
      beat(img_word(100));
      chk("t3_write100_we", 32'(bus.img_we), 32'h1);
      chk("t3_write100_addr", 32'(bus.img_addr), 32'd100);
      chk("t3_idle", 32'(bus.status[2:0]), 32'd0);
      chk("t3_no_abort", 32'(bus.npu_abort), 32'h0);
      for (int k = 0; k < 3; k++) beat(32'hDEAD_0000 + 32'(k));
      tick();
      chk("t3_img_we_count", 32'(img_we_cnt), 32'd101);
      chk("t3_abort_cnt", 32'(abort_cnt), 32'd0);
      bus.control_reg = 32'h0; tick();
      bus.control_reg = 32'h1; tick();
      beat(32'h1234_5678);
      chk("t3_restart_we", 32'(bus.img_we), 32'h1);
      chk("t3_restart_addr", 32'(bus.img_addr), 32'd0);

      // 6b: reset in the middle of LOAD_W
      for (int i = 1; i < N_IMG; i++) beat(img_word(i));
      for (int j = 0; j < 20; j++) beat(32'h0000_0100 + 32'(j));
      chk("t6_in_load_w", 32'(bus.status[2:0]), 32'd2);
      reset = 1'b1; tick();
      chk("t6_rst_status", 32'(bus.status), 32'h00);
      chk("t6_rst_busy", 32'(bus.busy), 32'h0);
      chk("t6_rst_w_we", 32'(bus.w_we), 32'h0);
      chk("t6_rst_w_addr", 32'(bus.w_addr), 32'h0);
      chk("t6_rst_img_addr", 32'(bus.img_addr), 32'h0);
      chk("t6_rst_w_wdata", 32'(bus.w_wdata), 32'h0);
      reset = 1'b0; tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
